// File: rtl/fp_add_seq.sv
// fp_add_seq -- sequenced IEEE-754 adder/subtractor with a start/done handshake.
// An internal FSM walks each operation through capture/swap, align, add,
// normalise and round. Denormal inputs are flushed to zero.
// Build option FP_ADD_ROUND_EN: when defined, the unit rounds to nearest-even
// on guard/round/sticky and handles NaN/infinity inputs. When undefined, GRS
// bits are truncated and all-ones exponents are treated as ordinary numbers.
module fp_add_seq #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      start,
    input  logic                      sub,
    input  logic [EXP_W+FRAC_W:0]     operando_a,
    input  logic [EXP_W+FRAC_W:0]     operando_b,
    output logic                      busy,
    output logic                      done,
    output logic [EXP_W+FRAC_W:0]     resultado,
    output logic                      overflow,
    output logic                      underflow
);
    localparam int W      = 1 + EXP_W + FRAC_W;
    localparam int MANT_W = FRAC_W + 4;   // hidden + fraction + guard/round/sticky
    localparam int MW     = FRAC_W + 5;   // MANT_W plus carry bit
    localparam int EW     = EXP_W + 1;    // exponent with one bit of headroom

    localparam logic [EXP_W-1:0] SHMAX_E   = EXP_W'(FRAC_W + 3);
    localparam logic [EW-1:0]    EXP_ONE   = {{(EW-1){1'b0}}, 1'b1};
    localparam logic [EW-1:0]    EXP_MAX_E = {1'b0, {EXP_W{1'b1}}};
    localparam logic [W-1:0]     QNAN      = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ALIGN = 3'd1,
        S_ADD   = 3'd2,
        S_NORM  = 3'd3,
        S_ROUND = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t            state_q, state_d;

    // Registered outputs
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;
    logic [W-1:0]      resultado_q, resultado_d;

    // Datapath registers
    logic              sign_q, sign_d;          // sign of the larger operand (result sign)
    logic              sign_sml_q, sign_sml_d;  // effective sign of the smaller operand
    logic [EW-1:0]     exp_q, exp_d;            // working exponent
    logic [EXP_W-1:0]  exp_sml_q, exp_sml_d;
    logic [MANT_W-1:0] mant_a_q, mant_a_d;
    logic [MANT_W-1:0] mant_b_q, mant_b_d;
    logic [MW-1:0]     m_q, m_d;                // sum / normalising mantissa
    logic [W-1:0]      res_q, res_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic              special_q, special_d;
    logic [W-1:0]      spec_res_q, spec_res_d;

    // Capture-side combinational signals
    logic              sign_a_s, sign_b_s;
    logic [EXP_W-1:0]  exp_a_s, exp_b_s;
    logic [W-2:0]      mag_a_s, mag_b_s;
    logic [W-2:0]      big_mag_s, sml_mag_s;
    logic              big_sign_s, sml_sign_s;
    logic              special_s;
    logic [W-1:0]      spec_res_s;
`ifdef FP_ADD_ROUND_EN
    logic              nan_a_s, nan_b_s, inf_a_s, inf_b_s;
`endif

    // Alignment and rounding combinational signals
    logic [EXP_W-1:0]  diff_s;
    logic [MANT_W-1:0] lost_mask_s, align_b_s;
    logic [FRAC_W:0]   sig_s;
    logic              rnd_up_s;
    logic [FRAC_W+1:0] sum_rnd_s;
    logic [EW-1:0]     exp_rnd_s;
    logic [FRAC_W-1:0] frac_rnd_s;
    logic              ovf_rnd_s;
    logic [W-1:0]      rnd_res_s;

    // Expand a flushed magnitude into hidden bit + fraction + empty GRS bits.
    function automatic logic [MANT_W-1:0] expand_mant(input logic [W-2:0] mag);
        expand_mant = {(|mag[W-2:FRAC_W]), mag[FRAC_W-1:0], 3'b000};
    endfunction

    assign busy      = busy_q;
    assign done      = done_q;
    assign resultado = resultado_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

    // Unpack operands, apply sub to B, flush denormals and order by magnitude
    always_comb begin
        sign_a_s = operando_a[W-1];
        sign_b_s = operando_b[W-1] ^ sub;
        exp_a_s  = operando_a[W-2:FRAC_W];
        exp_b_s  = operando_b[W-2:FRAC_W];
        mag_a_s  = (exp_a_s == {EXP_W{1'b0}}) ? {(W-1){1'b0}} : operando_a[W-2:0];
        mag_b_s  = (exp_b_s == {EXP_W{1'b0}}) ? {(W-1){1'b0}} : operando_b[W-2:0];
        if (mag_b_s > mag_a_s) begin
            big_mag_s  = mag_b_s;
            big_sign_s = sign_b_s;
            sml_mag_s  = mag_a_s;
            sml_sign_s = sign_a_s;
        end else begin
            big_mag_s  = mag_a_s;
            big_sign_s = sign_a_s;
            sml_mag_s  = mag_b_s;
            sml_sign_s = sign_b_s;
        end
    end

    // Classify NaN / infinity inputs and pick their fixed result
    always_comb begin
        special_s  = 1'b0;
        spec_res_s = {W{1'b0}};
`ifdef FP_ADD_ROUND_EN
        nan_a_s = (&exp_a_s) & (|operando_a[FRAC_W-1:0]);
        nan_b_s = (&exp_b_s) & (|operando_b[FRAC_W-1:0]);
        inf_a_s = (&exp_a_s) & ~(|operando_a[FRAC_W-1:0]);
        inf_b_s = (&exp_b_s) & ~(|operando_b[FRAC_W-1:0]);
        if (nan_a_s || nan_b_s) begin
            special_s  = 1'b1;
            spec_res_s = QNAN;
        end else if (inf_a_s && inf_b_s) begin
            special_s = 1'b1;
            if (sign_a_s == sign_b_s) begin
                spec_res_s = {sign_a_s, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
            end else begin
                spec_res_s = QNAN;
            end
        end else if (inf_a_s) begin
            special_s  = 1'b1;
            spec_res_s = {sign_a_s, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
        end else if (inf_b_s) begin
            special_s  = 1'b1;
            spec_res_s = {sign_b_s, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
        end else begin
            special_s  = 1'b0;
            spec_res_s = {W{1'b0}};
        end
`endif
    end

    // Right-shift the smaller mantissa by the exponent gap, folding lost bits into sticky
    always_comb begin
        diff_s      = exp_q[EXP_W-1:0] - exp_sml_q;
        lost_mask_s = ~({MANT_W{1'b1}} << diff_s);
        if (diff_s >= SHMAX_E) begin
            align_b_s = {{(MANT_W-1){1'b0}}, |mant_b_q};
        end else begin
            align_b_s = (mant_b_q >> diff_s)
                      | {{(MANT_W-1){1'b0}}, |(mant_b_q & lost_mask_s)};
        end
    end

    // Round the normalised mantissa and detect exponent saturation
    always_comb begin
        sig_s = m_q[MW-2:3];
`ifdef FP_ADD_ROUND_EN
        rnd_up_s = m_q[2] & (m_q[1] | m_q[0] | m_q[3]);
`else
        rnd_up_s = 1'b0;
`endif
        sum_rnd_s = {1'b0, sig_s} + {{(FRAC_W+1){1'b0}}, rnd_up_s};
        if (sum_rnd_s[FRAC_W+1]) begin
            exp_rnd_s  = exp_q + EXP_ONE;
            frac_rnd_s = sum_rnd_s[FRAC_W:1];
        end else begin
            exp_rnd_s  = exp_q;
            frac_rnd_s = sum_rnd_s[FRAC_W-1:0];
        end
        ovf_rnd_s = (exp_rnd_s >= EXP_MAX_E);
        if (ovf_rnd_s) begin
            rnd_res_s = {sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
        end else begin
            rnd_res_s = {sign_q, exp_rnd_s[EXP_W-1:0], frac_rnd_s};
        end
    end

    // FSM next state, datapath updates and output register next values
    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        resultado_d = resultado_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        sign_d      = sign_q;
        sign_sml_d  = sign_sml_q;
        exp_d       = exp_q;
        exp_sml_d   = exp_sml_q;
        mant_a_d    = mant_a_q;
        mant_b_d    = mant_b_q;
        m_d         = m_q;
        res_d       = res_q;
        ovf_d       = ovf_q;
        unf_d       = unf_q;
        special_d   = special_q;
        spec_res_d  = spec_res_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_ALIGN;
                    busy_d      = 1'b1;
                    overflow_d  = 1'b0;
                    underflow_d = 1'b0;
                    sign_d      = big_sign_s;
                    sign_sml_d  = sml_sign_s;
                    exp_d       = {1'b0, big_mag_s[W-2:FRAC_W]};
                    exp_sml_d   = sml_mag_s[W-2:FRAC_W];
                    mant_a_d    = expand_mant(big_mag_s);
                    mant_b_d    = expand_mant(sml_mag_s);
                    res_d       = {W{1'b0}};
                    ovf_d       = 1'b0;
                    unf_d       = 1'b0;
                    special_d   = special_s;
                    spec_res_d  = spec_res_s;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ALIGN: begin
                mant_b_d = align_b_s;
                state_d  = S_ADD;
            end
            S_ADD: begin
                if (sign_q == sign_sml_q) begin
                    m_d = {1'b0, mant_a_q} + {1'b0, mant_b_q};
                end else begin
                    m_d = {1'b0, mant_a_q} - {1'b0, mant_b_q};
                end
                state_d = S_NORM;
            end
            S_NORM: begin
                if (special_q) begin
                    state_d = S_ROUND;
                end else if (m_q[MW-1]) begin
                    // carry out: one right shift, sticky keeps the dropped bit
                    m_d     = {1'b0, m_q[MW-1:2], m_q[1] | m_q[0]};
                    exp_d   = exp_q + EXP_ONE;
                    state_d = S_ROUND;
                end else if (m_q == {MW{1'b0}}) begin
                    // exact cancellation always yields +0
                    res_d   = {W{1'b0}};
                    state_d = S_DONE;
                end else if (m_q[MW-2]) begin
                    state_d = S_ROUND;
                end else if (exp_q <= EXP_ONE) begin
                    unf_d   = 1'b1;
                    res_d   = {sign_q, {(W-1){1'b0}}};
                    state_d = S_DONE;
                end else begin
                    m_d     = {m_q[MW-2:0], 1'b0};
                    exp_d   = exp_q - EXP_ONE;
                    state_d = S_NORM;
                end
            end
            S_ROUND: begin
                if (special_q) begin
                    res_d = spec_res_q;
                    ovf_d = 1'b0;
                end else begin
                    res_d = rnd_res_s;
                    ovf_d = ovf_rnd_s;
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                done_d      = 1'b1;
                busy_d      = 1'b0;
                resultado_d = res_q;
                overflow_d  = ovf_q;
                underflow_d = unf_q;
                state_d     = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Output registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            resultado_q <= {W{1'b0}};
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            busy_q      <= busy_d;
            done_q      <= done_d;
            resultado_q <= resultado_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Datapath registers; an in-flight operation is discarded on reset
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sign_q     <= 1'b0;
            sign_sml_q <= 1'b0;
            exp_q      <= {EW{1'b0}};
            exp_sml_q  <= {EXP_W{1'b0}};
            mant_a_q   <= {MANT_W{1'b0}};
            mant_b_q   <= {MANT_W{1'b0}};
            m_q        <= {MW{1'b0}};
            res_q      <= {W{1'b0}};
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
            special_q  <= 1'b0;
            spec_res_q <= {W{1'b0}};
        end else begin
            sign_q     <= sign_d;
            sign_sml_q <= sign_sml_d;
            exp_q      <= exp_d;
            exp_sml_q  <= exp_sml_d;
            mant_a_q   <= mant_a_d;
            mant_b_q   <= mant_b_d;
            m_q        <= m_d;
            res_q      <= res_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
            special_q  <= special_d;
            spec_res_q <= spec_res_d;
        end
    end

endmodule
